// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM block reader and its output FIFO.
package ram_stream_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;
    localparam int FIFO_DEPTH = 2;
    localparam int RD_LATENCY = 1;
endpackage

// File: rtl/stream_fifo2.sv
// Two-entry data+last FIFO with fall-through: an incoming word is visible on the
// output in the cycle it is pushed, so an empty FIFO adds no latency.
module stream_fifo2 import ram_stream_pkg::*; #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o,
    output logic [1:0]   count_o
);
    logic [W:0] mem_q [FIFO_DEPTH];
    logic       rd_ptr_q, wr_ptr_q;
    logic [1:0] cnt_q;
    logic       empty, do_pop, store, adv;

    assign empty   = (cnt_q == 2'd0);
    assign valid_o = !empty || push_i;
    assign count_o = cnt_q;
    assign do_pop  = pop_i && valid_o;
    // A word pushed into an empty FIFO and popped in the same cycle is never stored.
    assign store   = push_i && !(empty && do_pop);
    assign adv     = do_pop && !empty;

    always_comb begin
        {last_o, data_o} = '0;
        if (!empty)      {last_o, data_o} = mem_q[rd_ptr_q];
        else if (push_i) {last_o, data_o} = {last_i, data_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (store) begin
                mem_q[wr_ptr_q] <= {last_i, data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (adv) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, store} - {1'b0, adv};
        end
    end
endmodule

// File: rtl/ram_stream_reader.sv
// Reads a block of RAM words and emits them as a valid/ready stream with a last flag,
// hiding the RAM read latency and absorbing consumer backpressure.
module ram_stream_reader import ram_stream_pkg::*; #(
    parameter int ADD_SIZE  = 11,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADD_SIZE-1:0]  base_addr,
    input  logic [ADD_SIZE:0]    length,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_read_en,
    output logic [ADD_SIZE-1:0]  ram_read_address,
    input  logic [DATA_SIZE-1:0] ram_dataOut,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);
    state_e                  state_q, state_d;
    logic [ADD_SIZE-1:0]     addr_q, addr_d;
    logic [ADD_SIZE:0]       reads_rem_q, reads_rem_d;
    logic [ADD_SIZE:0]       beats_rem_q, beats_rem_d;
    logic                    done_q, done_d;
    logic [RD_LATENCY-1:0]   rd_vld_q, rd_last_q;
    logic [1:0]              fifo_cnt, inflight, occ;
    logic                    read_en, read_is_last, beat;

    // Credit: stored words plus reads in flight may never exceed the FIFO depth.
    assign inflight     = 2'($countones(rd_vld_q));
    assign occ          = fifo_cnt + inflight;
    assign read_en      = (state_q == READ) && (reads_rem_q != '0) && (occ < 2'(FIFO_DEPTH));
    assign read_is_last = (reads_rem_q == (ADD_SIZE+1)'(1));
    assign beat         = m_valid && m_ready;

    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign ram_read_en      = read_en;
    assign ram_read_address = addr_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        reads_rem_d = reads_rem_q;
        beats_rem_d = beats_rem_q;
        done_d      = 1'b0;
        if (beat) beats_rem_d = beats_rem_q - 1'b1;
        case (state_q)
            IDLE: if (start) begin
                addr_d      = base_addr;
                reads_rem_d = length;
                beats_rem_d = length;
                // Empty block: finish through DRAIN so busy covers the done cycle.
                if (length == '0) begin
                    state_d = DRAIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ;
                end
            end
            READ: if (read_en) begin
                addr_d      = addr_q + 1'b1;
                reads_rem_d = reads_rem_q - 1'b1;
                if (read_is_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (beats_rem_q == '0) begin
                    state_d = IDLE;
                end else if (beat && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            reads_rem_q <= '0;
            beats_rem_q <= '0;
            done_q      <= 1'b0;
            rd_vld_q    <= '0;
            rd_last_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            reads_rem_q <= reads_rem_d;
            beats_rem_q <= beats_rem_d;
            done_q      <= done_d;
            rd_vld_q    <= (rd_vld_q << 1) | RD_LATENCY'(read_en);
            rd_last_q   <= (rd_last_q << 1) | RD_LATENCY'(read_en && read_is_last);
        end
    end

    stream_fifo2 #(.W(DATA_SIZE)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (rd_vld_q[RD_LATENCY-1]),
        .data_i  (ram_dataOut),
        .last_i  (rd_last_q[RD_LATENCY-1]),
        .pop_i   (m_ready),
        .valid_o (m_valid),
        .data_o  (m_data),
        .last_o  (m_last),
        .count_o (fifo_cnt)
    );
endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model, expected-stream scoreboard, directed blocks.
module tb_ram_stream_reader;
    localparam int AW = 11;
    localparam int LW = AW + 1;
    localparam int DW = 32;
    localparam int N  = 1 << AW;

    typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, ram_read_en, m_valid, m_last;
    logic [AW-1:0] ram_read_address;
    logic [DW-1:0] ram_dataOut = '0, m_data;
    logic [DW-1:0] mem [N];

    int pass_cnt = 0, total_cnt = 0, cyc = 0;
    int reads_n = 0, beats_n = 0;
    beat_t         exp_q[$], log_q[$];
    logic [AW-1:0] exp_addr_q[$], addr_log[$];
    int            beat_cyc[$];
    logic          prev_stall = 1'b0;
    beat_t         prev_beat;

    ram_stream_reader #(.ADD_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .ram_read_en(ram_read_en), .ram_read_address(ram_read_address),
        .ram_dataOut(ram_dataOut), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data valid the cycle after the strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_read_en) ram_dataOut <= mem[ram_read_address];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        total_cnt++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Scoreboard: every presented word, every read address, and the credit bound.
    always @(negedge clk) begin
        if (rst) begin
            if (m_valid) begin
                if (prev_stall) chk("stall_hold", {m_data, m_last}, prev_beat);
                if (exp_q.size() == 0) fail("unexpected_beat");
                else chk("beat", {m_data, m_last}, exp_q[0]);
                if (m_ready) begin
                    log_q.push_back({m_data, m_last});
                    beat_cyc.push_back(cyc);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    beats_n++;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_data, m_last};
            if (ram_read_en) begin
                addr_log.push_back(ram_read_address);
                reads_n++;
                if (exp_addr_q.size() == 0) fail("unexpected_read");
                else chk("read_addr", ram_read_address, exp_addr_q.pop_front());
            end
            if (ram_read_en || m_valid) chk("credit", (reads_n - beats_n) <= 2, 1);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_logs();
        log_q.delete(); beat_cyc.delete(); addr_log.delete();
        reads_n = 0; beats_n = 0;
    endtask

    task automatic do_start(input int base, input int len, input bit accept, output int s);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(base); length = LW'(len);
        s = cyc;
        if (accept) for (int i = 0; i < len; i++) begin
            exp_q.push_back({mem[(base + i) % N], (i == len - 1)});
            exp_addr_q.push_back(AW'((base + i) % N));
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done) begin dc = cyc; break; end
        end
        if (dc < 0) fail("done_timeout");
    endtask

    task automatic idle_gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int s, dc, r0, nlast;
    bit pat [6] = '{1, 0, 0, 1, 0, 1};

    initial begin
        for (int i = 0; i < N; i++) mem[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        mem[0] = 32'h0; mem[1] = 32'h124; mem[2] = 32'h165;

        // Reset state
        @(negedge clk);
        chk("reset_outputs", {busy, done, ram_read_en, ram_read_address, m_data, m_valid, m_last}, 0);
        @(posedge clk); #1 rst = 1'b1;
        idle_gap(2);

        // Basic 3-word block, full throughput
        m_ready = 1'b1; clear_logs();
        do_start(0, 3, 1, s);
        @(negedge clk); chk("t1_busy_after_start", busy, 1);
        wait_done(40, dc);
        chk("t1_done_cycle", dc, s + 5);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_nbeats", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t1_w0", log_q[0], {32'h0, 1'b0});
            chk("t1_w1", log_q[1], {32'h124, 1'b0});
            chk("t1_w2", log_q[2], {32'h165, 1'b1});
            chk("t1_first_beat_cycle", beat_cyc[0], s + 2);
            chk("t1_last_beat_cycle", beat_cyc[2], s + 4);
        end
        idle_gap(2);

        // Address wrap
        clear_logs();
        do_start(12'h7FE, 4, 1, s);
        wait_done(40, dc);
        chk("t2_nreads", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("t2_a0", addr_log[0], 11'h7FE);
            chk("t2_a1", addr_log[1], 11'h7FF);
            chk("t2_a2", addr_log[2], 11'h000);
            chk("t2_a3", addr_log[3], 11'h001);
        end
        nlast = 0; foreach (log_q[i]) nlast += int'(log_q[i].l);
        chk("t2_nbeats", log_q.size(), 4);
        chk("t2_nlast", nlast, 1);
        idle_gap(2);

        // Backpressure 1,0,0,1,0,1...
        clear_logs();
        do_start(12'h100, 5, 1, s);
        dc = -1;
        for (int i = 0; i < 300 && dc < 0; i++) begin
            m_ready = pat[i % 6];
            @(negedge clk); #1;
            if (done) dc = cyc;
            @(posedge clk); #1;
        end
        if (dc < 0) fail("t3_done_timeout");
        chk("t3_nbeats", log_q.size(), 5);
        chk("t3_exp_drained", exp_q.size(), 0);
        m_ready = 1'b1;
        idle_gap(2);

        // Zero-length block
        clear_logs();
        do_start(12'h050, 0, 1, s);
        @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 1);
        @(negedge clk);
        chk("t4_done_fall", done, 0);
        chk("t4_busy_fall", busy, 0);
        idle_gap(2);
        chk("t4_no_reads", reads_n, 0);
        chk("t4_no_beats", beats_n, 0);

        // Mid-block reset after 2 beats
        clear_logs();
        do_start(12'h200, 8, 1, s);
        for (int i = 0; i < 50 && log_q.size() < 2; i++) begin @(negedge clk); #1; end
        if (log_q.size() < 2) fail("t5_two_beats_timeout");
        @(posedge clk); #1 rst = 1'b0;
        #1 chk("t5_reset_outputs", {busy, done, ram_read_en, ram_read_address, m_data, m_valid, m_last}, 0);
        exp_q.delete(); exp_addr_q.delete();
        chk("t5_beats_before_reset", log_q.size(), 2);
        idle_gap(2);
        rst = 1'b1;
        idle_gap(1);
        clear_logs();
        do_start(12'h300, 3, 1, s);
        wait_done(40, dc);
        chk("t5_restart_nbeats", log_q.size(), 3);
        if (log_q.size() == 3) chk("t5_restart_first", log_q[0].d, mem[12'h300]);
        idle_gap(2);

        // Start while busy is ignored
        clear_logs(); m_ready = 1'b0;
        do_start(12'h400, 6, 1, s);
        idle_gap(1);
        start = 1'b1; base_addr = 11'h010; length = 12'd2;
        idle_gap(1);
        start = 1'b0;
        m_ready = 1'b1;
        wait_done(60, dc);
        chk("t6_nbeats", log_q.size(), 6);
        if (log_q.size() == 6) chk("t6_last_word", log_q[5], {mem[12'h405], 1'b1});
        idle_gap(4);
        chk("t6_idle_after", busy, 0);
        chk("t6_no_extra_reads", reads_n, 6);

        // Start coincident with the final-beat handshake is ignored
        clear_logs();
        do_start(12'h500, 2, 1, s);
        idle_gap(2);
        start = 1'b1; base_addr = 11'h600; length = 12'd3;
        idle_gap(1);
        start = 1'b0;
        @(negedge clk);
        chk("t7_done", done, 1);
        chk("t7_busy_fall", busy, 0);
        @(negedge clk);
        chk("t7_stay_idle", busy, 0);
        idle_gap(3);
        chk("t7_no_extra_reads", reads_n, 2);

        // Full-RAM block
        clear_logs();
        do_start(12'h005, N, 1, s);
        wait_done(N + 200, dc);
        chk("t8_nbeats", log_q.size(), N);
        nlast = 0; foreach (log_q[i]) nlast += int'(log_q[i].l);
        chk("t8_nlast", nlast, 1);
        chk("t8_done_cycle", dc, s + 2 + N);
        chk("t8_exp_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
